prewitt_stream: RTL and testbench

PREWITT_STREAM -- requirements
Module: prewitt_stream

---
 rtl/prewitt_stream.sv | 122 ++++++++++++
 tb/tb_prewitt_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/prewitt_stream.sv
// Streaming 3x3 Prewitt edge filter over raster pixels, two line buffers plus a sliding window.
// Latency 2 cycles from the completing accept; no backpressure, stages advance every cycle.
module prewitt_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_pix,
    input  logic [1:0]    mode,
    output logic          out_valid,
    output logic          out_sof,
    output logic          out_eol,
    output logic [DW-1:0] out_pix
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SW = DW + 2;
    localparam int AW = DW + 4;
    localparam logic [DW-1:0] MAXV = {DW{1'b1}};

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [1:0]    row_q, row_d, cur_row;
    logic          frame_q;
    logic          res_vld;

    logic [DW-1:0] lb0_q [IMG_W];
    logic [DW-1:0] lb1_q [IMG_W];
    logic [DW-1:0] win_q [3][2];
    logic [DW-1:0] top_px, mid_px;

    logic          s1_vld_q, s1_sof_q, s1_eol_q;
    logic [1:0]    s1_mode_q;
    logic [SW-1:0] rt_q, rb_q, cl_q, cr_q;
    logic [SW-1:0] ax, ay;
    logic [DW-1:0] res_d;

    function automatic logic [SW-1:0] sum3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return SW'(a) + SW'(b) + SW'(c);
    endfunction

    function automatic logic [DW-1:0] clamp(input logic [AW-1:0] v);
        return (v > AW'(MAXV)) ? MAXV : v[DW-1:0];
    endfunction

    // A start-of-frame pixel overrides whatever position the counters hold.
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? '0 : row_q;
    assign top_px  = lb1_q[cur_col];
    assign mid_px  = lb0_q[cur_col];
    assign res_vld = in_valid && (cur_row == 2'd2) && (cur_col >= CW'(2));

    always_comb begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
        if (cur_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            frame_q   <= 1'b1;
            s1_vld_q  <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_pix   <= '0;
        end else begin
            if (in_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                if (cur_row == 2'd0 && cur_col == '0)
                    frame_q <= 1'b1;
                else if (res_vld)
                    frame_q <= 1'b0;
            end
            s1_vld_q  <= res_vld;
            out_valid <= s1_vld_q;
            out_sof   <= s1_vld_q && s1_sof_q;
            out_eol   <= s1_vld_q && s1_eol_q;
            out_pix   <= s1_vld_q ? res_d : '0;
        end
    end

    // Storage and datapath registers carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1_q[cur_col] <= mid_px;
            lb0_q[cur_col] <= in_pix;
            for (int k = 0; k < 3; k++) win_q[k][0] <= win_q[k][1];
            win_q[0][1] <= top_px;
            win_q[1][1] <= mid_px;
            win_q[2][1] <= in_pix;
        end
        s1_sof_q  <= frame_q;
        s1_eol_q  <= (cur_col == CW'(IMG_W - 1));
        s1_mode_q <= mode;
        rt_q      <= sum3(win_q[0][0], win_q[0][1], top_px);
        rb_q      <= sum3(win_q[2][0], win_q[2][1], in_pix);
        cl_q      <= sum3(win_q[0][0], win_q[1][0], win_q[2][0]);
        cr_q      <= sum3(top_px, mid_px, in_pix);
    end

    assign ax = (rb_q >= rt_q) ? rb_q - rt_q : rt_q - rb_q;
    assign ay = (cr_q >= cl_q) ? cr_q - cl_q : cl_q - cr_q;

    always_comb begin
        res_d = '0;
        case (s1_mode_q)
            2'd0:    res_d = (rt_q > rb_q) ? '0 : clamp(AW'(ax));
            2'd1:    res_d = (cl_q > cr_q) ? '0 : clamp(AW'(ay));
            2'd2:    res_d = clamp(AW'(ax) + AW'(ay));
            default: res_d = clamp(AW'((ax >= ay) ? ax : ay));
        endcase
    end
endmodule

// File: tb/tb_prewitt_stream.sv
// Randomised stream bench for prewitt_stream, checked against a frame-level arithmetic model.
module tb_prewitt_stream;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int MX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_pix = '0;
    logic [1:0]    mode = 2'd0;
    logic          out_valid, out_sof, out_eol;
    logic [DW-1:0] out_pix;

    prewitt_stream #(.DW(DW), .IMG_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
        .mode(mode), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
        .out_pix(out_pix)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int pix;
        bit sof;
        bit eol;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, cyc = 0, nres = 0;
    int   mr = 0, mc = 0;
    int   img[3][W];
    bit   rst_seen = 1'b0;
    int   top, bot, lft, rgt, gx, gy, ev;
    bit   exp_v;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > MX) ? MX : v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: keep the last three image lines and apply the kernel directly.
    always @(posedge clk) begin
        cyc++;
        rst_seen = rst;
        if (rst) begin
            q.delete();
            mr = 0;
            mc = 0;
        end else if (in_valid) begin
            if (in_sof) begin
                mr = 0;
                mc = 0;
            end
            img[mr % 3][mc] = in_pix;
            if (mr >= 2 && mc >= 2) begin
                top = 0; bot = 0; lft = 0; rgt = 0;
                for (int k = 0; k < 3; k++) begin
                    top += img[(mr - 2) % 3][mc - 2 + k];
                    bot += img[mr % 3][mc - 2 + k];
                    lft += img[(mr - 2 + k) % 3][mc - 2];
                    rgt += img[(mr - 2 + k) % 3][mc];
                end
                gx = bot - top;
                gy = rgt - lft;
                case (mode)
                    2'd0:    ev = sat(gx);
                    2'd1:    ev = sat(gy);
                    2'd2:    ev = sat(iabs(gx) + iabs(gy));
                    default: ev = sat((iabs(gx) > iabs(gy)) ? iabs(gx) : iabs(gy));
                endcase
                q.push_back('{due: cyc + 1, pix: ev, sof: (mr == 2 && mc == 2), eol: (mc == W - 1)});
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_seen) begin
            check_eq("rst_valid", out_valid, 0);
            check_eq("rst_sof", out_sof, 0);
            check_eq("rst_eol", out_eol, 0);
            check_eq("rst_pix", out_pix, 0);
        end else begin
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            check_eq("valid", out_valid, exp_v);
            if (exp_v) begin
                if (out_valid) begin
                    check_eq("pix", out_pix, q[0].pix);
                    check_eq("sof", out_sof, q[0].sof);
                    check_eq("eol", out_eol, q[0].eol);
                    nres++;
                end
                void'(q.pop_front());
            end
        end
    end

    // kind: 0 const 100, 1 two dark lines then 255, 2 two 200 lines then 0, 3 vertical step, else random.
    // md > 3 picks a random mode per pixel; stop_after >= 0 abandons the frame after that many pixels.
    task automatic send_frame(input int h, input int kind, input int md, input int gap,
                              input bit sof, input int stop_after);
        int n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < W; c++) begin
                if (stop_after >= 0 && n == stop_after) return;
                while ($urandom_range(99) < gap) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    in_sof   = 1'b0;
                end
                @(posedge clk); #1;
                in_valid = 1'b1;
                in_sof   = sof && (r == 0) && (c == 0);
                case (kind)
                    0:       in_pix = 8'd100;
                    1:       in_pix = (r < 2) ? 8'd0 : 8'd255;
                    2:       in_pix = (r < 2) ? 8'd200 : 8'd0;
                    3:       in_pix = (c < 4) ? 8'd0 : 8'd30;
                    default: in_pix = 8'($urandom_range(MX));
                endcase
                mode = (md > 3) ? 2'($urandom_range(3)) : 2'(md);
                n++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        nres = 0; send_frame(5, 0, 0, 0, 1, -1); drain(); check_eq("n_const", nres, 18);
        nres = 0; send_frame(5, 1, 0, 0, 1, -1); drain(); check_eq("n_rise", nres, 18);
        nres = 0; send_frame(5, 2, 0, 0, 1, -1); drain(); check_eq("n_fall", nres, 18);
        nres = 0; send_frame(5, 3, 2, 0, 1, -1); drain(); check_eq("n_step_m2", nres, 18);
        nres = 0; send_frame(5, 3, 3, 0, 1, -1); drain(); check_eq("n_step_m3", nres, 18);
        nres = 0; send_frame(5, 3, 1, 0, 1, -1); drain(); check_eq("n_step_m1", nres, 18);
        nres = 0; send_frame(5, 1, 0, 50, 1, -1); drain(); check_eq("n_gaps", nres, 18);

        nres = 0;
        repeat (4) send_frame(5, 4, 4, 30, 1, -1);
        drain(); check_eq("n_random", nres, 72);

        nres = 0;
        send_frame(5, 4, 4, 20, 1, 20);
        send_frame(4, 4, 4, 0, 1, -1);
        drain(); check_eq("n_midsof", nres, 14);

        nres = 0;
        send_frame(5, 4, 4, 0, 1, 28);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        drain(); check_eq("n_pre_rst", nres, 7);
        nres = 0;
        send_frame(5, 4, 4, 25, 0, -1);
        drain(); check_eq("n_post_rst", nres, 18);

        check_eq("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
